// File: rtl/riscv_pkg.sv
// Shared constants and types for the decode-stage hazard controller.
package riscv_pkg;

  localparam int NUM_REGS     = 32;
  localparam int REG_AW       = 5;
  localparam int SB_W         = 3;
  localparam int FLUSH_CYCLES = 2;

  // Scoreboard value marking a register owned by the long-latency unit.
  localparam logic [SB_W-1:0] LONG_TAG = 3'd7;

  typedef enum logic [1:0] {
    S_RUN,
    S_STALL,
    S_FLUSH
  } hz_state_e;

endpackage

// File: rtl/dec_scoreboard.sv
// Register scoreboard: one countdown per architectural register giving the
// cycles until its pending result can be forwarded, plus the tracking of the
// single in-flight long-latency (mul/div) destination.
module dec_scoreboard
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic              wr_long,
  input  logic [REG_AW-1:0] wr_adr,
  input  logic [SB_W-1:0]   wr_val,
  input  logic              long_done,
  input  logic [REG_AW-1:0] rs1_adr,
  input  logic [REG_AW-1:0] rs2_adr,
  output logic [SB_W-1:0]   rs1_tag,
  output logic [SB_W-1:0]   rs2_tag,
  output logic              long_busy_q
);

  logic [SB_W-1:0]   sb_q [NUM_REGS];
  logic [REG_AW-1:0] long_rd_q;
  logic              done_eff;

  // A completion pulse with nothing in flight is meaningless and dropped.
  assign done_eff = long_done & long_busy_q;

  assign rs1_tag = sb_q[rs1_adr];
  assign rs2_tag = sb_q[rs2_adr];

  // Per-entry countdown with clear-on-done and issue-write priority; x0 pinned to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is only 32x3 flops and a stale nonzero entry would
      // stall decode forever, so it is reset like any other state.
      for (int i = 0; i < NUM_REGS; i++) sb_q[i] <= '0;
      long_rd_q   <= '0;
      long_busy_q <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) sb_q[i] <= '0;
      long_busy_q <= 1'b0;
    end else begin
      sb_q[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        // NOTE: non-blocking assignments here mean every entry sees the
        // pre-edge value of sb_q, so the loop order cannot leak between entries.
        if (wr_en && wr_adr == REG_AW'(i)) begin
          sb_q[i] <= wr_val;
        end else if (done_eff && long_rd_q == REG_AW'(i)) begin
          sb_q[i] <= '0;
        end else if (sb_q[i] != '0 && !(long_busy_q && long_rd_q == REG_AW'(i))) begin
          sb_q[i] <= sb_q[i] - SB_W'(1);
        end
      end
      // A new long issue in the same cycle as done overrides the clear.
      if (wr_en && wr_long) begin
        long_busy_q <= 1'b1;
        long_rd_q   <= wr_adr;
      end else if (done_eff) begin
        long_busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dec_hazard_ctrl.sv
// Decode-stage hazard control: detects data and structural hazards against
// the register scoreboard, stalls/issues/bubbles, and sequences pipeline flush.
module dec_hazard_ctrl #(
  parameter logic [2:0] LONG_TAG = riscv_pkg::LONG_TAG
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_instr_v_i,
  input  logic        dec_rs1_v_i,
  input  logic [4:0]  dec_rs1_adr_i,
  input  logic        dec_rs2_v_i,
  input  logic [4:0]  dec_rs2_adr_i,
  input  logic        dec_rd_v_i,
  input  logic [4:0]  dec_rd_adr_i,
  input  logic [2:0]  dec_lat_i,
  input  logic        dec_long_op_i,
  input  logic        long_op_done_i,
  input  logic        flush_v_q_i,
  output logic        stall_o,
  output logic        issue_o,
  output logic        bubble_o,
  output logic        long_busy_q_o,
  output logic [31:0] stall_cnt_q_o
);

  import riscv_pkg::SB_W;
  import riscv_pkg::FLUSH_CYCLES;
  import riscv_pkg::hz_state_e;
  import riscv_pkg::S_RUN;
  import riscv_pkg::S_STALL;
  import riscv_pkg::S_FLUSH;

  hz_state_e       state_q;
  logic [1:0]      flush_cnt_q;
  logic [SB_W-1:0] rs1_tag;
  logic [SB_W-1:0] rs2_tag;
  logic            data_haz;
  logic            struct_haz;
  logic            sb_wr_en;
  logic [SB_W-1:0] sb_wr_val;

  assign data_haz   = (dec_rs1_v_i && rs1_tag != '0) || (dec_rs2_v_i && rs2_tag != '0);
  assign struct_haz = dec_long_op_i && long_busy_q_o && !long_op_done_i;

  // Combinational stall / issue / bubble decision for the decode instruction.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch forms.
    stall_o  = 1'b0;
    issue_o  = 1'b0;
    bubble_o = 1'b0;
    if (state_q == S_FLUSH) begin
      bubble_o = 1'b1;
    end else begin
      stall_o  = dec_instr_v_i && (data_haz || struct_haz);
      bubble_o = stall_o;
      // The flush cycle itself must not let an instruction into EXE.
      issue_o  = dec_instr_v_i && !stall_o && !flush_v_q_i;
    end
  end

  // Writes to x0 are discarded so they can never create a hazard.
  assign sb_wr_en  = issue_o && dec_rd_v_i && (dec_rd_adr_i != '0);
  assign sb_wr_val = dec_long_op_i ? LONG_TAG : dec_lat_i - 3'd1;

  dec_scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush_v_q_i),
    .wr_en       (sb_wr_en),
    .wr_long     (dec_long_op_i),
    .wr_adr      (dec_rd_adr_i),
    .wr_val      (sb_wr_val),
    .long_done   (long_op_done_i),
    .rs1_adr     (dec_rs1_adr_i),
    .rs2_adr     (dec_rs2_adr_i),
    .rs1_tag     (rs1_tag),
    .rs2_tag     (rs2_tag),
    .long_busy_q (long_busy_q_o)
  );

  // RUN/STALL/FLUSH sequencing; flush from any state restarts the FLUSH window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
    end else if (flush_v_q_i) begin
      state_q     <= S_FLUSH;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        S_RUN:   if (stall_o) state_q <= S_STALL;
        S_STALL: if (!stall_o) state_q <= S_RUN;
        S_FLUSH: begin
          if (flush_cnt_q == 2'(FLUSH_CYCLES - 1)) state_q <= S_RUN;
          else flush_cnt_q <= flush_cnt_q + 2'd1;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q_o <= '0;
    end else if (stall_o && stall_cnt_q_o != '1) begin
      stall_cnt_q_o <= stall_cnt_q_o + 32'd1;
    end
  end

endmodule
